lfsr_rng_ctrl: RTL
==================

// Module: lfsr_rng_ctrl
// PURPOSE
//   Sequencer and arbiter for the shared 26-bit LFSR random source.
//   - Seeds the LFSR through its load/din pins and re-seeds it on request.
//   - Enforces a warm-up gap after each seed or draw.
//   - Serves N requesters round-robin: one registered snapshot of q per grant.
//   Sits between the LFSR instance and its consumers. The LFSR free-runs every clk.
// PARAMETERS
//   W            26          LFSR width; lfsr_din, lfsr_q, seed_data, rnd_data
//   N            4           requester count, 2..8
//   GAP          4           warm-up cycles after a seed or grant, >=1
//   SEED_DEFAULT 26'h3084F27 nonzero seed used at reset, on seed_data==0, on lockup
// PORTS
//   clk         in   1   single clock, rising edge
//   rst_n       in   1   synchronous active-low reset
//   req         in   N   request per requester; held until gnt, may drop early
//   gnt         out  N   one-hot grant, 1-cycle pulse
//   rnd_valid   out  1   high with gnt; rnd_data is valid
//   rnd_data    out  W   LFSR snapshot for the granted requester
//   seed_req    in   1   reseed request, level, sampled in IDLE
//   seed_data   in   W   seed value taken with seed_req
//   lfsr_load   out  1   to LFSR load pin
//   lfsr_din    out  W   to LFSR din pin
//   lfsr_q      in   W   from LFSR q
//   busy        out  1   state != IDLE
//   lockup_cnt  out  8   saturating count of all-zero recoveries
// BEHAVIOUR
//   All outputs are registered.
//   Reset (rst_n==0 at posedge):
//     - gnt=0, rnd_valid=0, rnd_data=0, lfsr_load=0, lfsr_din=0, lockup_cnt=0.
//     - Round-robin pointer -> req[0] highest priority.
//     - State -> SEED with seed value SEED_DEFAULT.
//     - Applies mid-operation too: any pending grant is dropped.
//   States: SEED -> WARM -> IDLE -> SERVE -> WARM -> IDLE ...
//   SEED (1 cycle)
//     - lfsr_load=1, lfsr_din=selected seed.
//     - Next state WARM; warm counter loads GAP-1.
//   WARM (GAP cycles)
//     - lfsr_load=0; counter decrements; at 0 -> IDLE.
//     - req and seed_req are ignored; requesters keep req held.
//   IDLE, priority order:
//     1. Lockup (macro only), see CONFIGURATION.
//     2. seed_req=1: SEED with seed_data, or SEED_DEFAULT if seed_data==0.
//     3. Any req: pick the first asserted requester at or after the pointer,
//        wrapping N-1 -> 0.
//        rnd_data <= lfsr_q sampled at this edge; go to SERVE.
//   SERVE (1 cycle)
//     - gnt=one-hot winner, rnd_valid=1.
//     - Pointer <= winner+1 mod N; next state WARM.
//   Timing
//     - gnt appears the cycle after the IDLE edge that sampled req.
//     - A continuously held req is granted every GAP+2 cycles.
//   Simultaneous events
//     - seed_req and req together: seed wins; req is served after the warm-up.
//     - req dropped before its grant: no grant; the pointer does not move.
//   Boundaries
//     - Pointer wraps modulo N.
//     - lockup_cnt holds at 8'hFF.
//     - lfsr_din is held at its last seed value outside SEED.
// CONFIGURATION
//   LFSR_LOCKUP_DET_EN defined
//     - In IDLE or WARM, lfsr_q==0 forces SEED with SEED_DEFAULT.
//     - lockup_cnt += 1.
//     - In IDLE, lockup takes priority over seed_req and req.
//   LFSR_LOCKUP_DET_EN undefined
//     - No zero check; lockup_cnt is tied to 8'h00.
// TESTING
//   T1 Reset: rst_n=0 for 2 clk, then release
//      -> lfsr_load=1 for exactly 1 cycle, lfsr_din=26'h3084F27
//      -> busy=1 for GAP+1=5 cycles, then busy=0.
//   T2 Single request: req=4'b0100 in IDLE
//      -> next cycle gnt=4'b0100, rnd_valid=1, rnd_data=lfsr_q at the sampling edge
//      -> busy for 5 cycles (1 SERVE + 4 WARM).
//   T3 Round-robin: req=4'b1111 held
//      -> gnt order 0001, 0010, 0100, 1000, 0001, spaced 6 cycles apart.
//   T4 Seed vs. request: seed_req=1, seed_data=0, req=4'b0001 in the same IDLE cycle
//      -> lfsr_load pulse with din=26'h3084F27
//      -> gnt=4'b0001 one cycle after the following IDLE edge.
//   T5 Lockup: force lfsr_q=0 in IDLE
//      -> with LFSR_LOCKUP_DET_EN: lfsr_load pulse (SEED_DEFAULT), lockup_cnt 0->1
//      -> without the macro: no load, lockup_cnt=0.
//   T6 Reset mid-WARM: rst_n=0 for 1 clk during WARM
//      -> next cycle gnt=0, rnd_valid=0, lockup_cnt=0
//      -> after release, the T1 sequence repeats.

Source files
------------

// File: rtl/lfsr_rng_ctrl.sv
// Sequencer/arbiter for a shared free-running LFSR: seeds it, enforces a warm-up gap,
// and hands one registered q snapshot per grant to N round-robin requesters.
// Optional build macro: LFSR_LOCKUP_DET_EN (all-zero detection and automatic reseed).
module lfsr_rng_ctrl #(
  parameter int          W            = 26,
  parameter int          N            = 4,
  parameter int          GAP          = 4,
  parameter logic [W-1:0] SEED_DEFAULT = 26'h3084F27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         rnd_valid,
  output logic [W-1:0] rnd_data,
  input  logic         seed_req,
  input  logic [W-1:0] seed_data,
  output logic         lfsr_load,
  output logic [W-1:0] lfsr_din,
  input  logic [W-1:0] lfsr_q,
  output logic         busy,
  output logic [7:0]   lockup_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {SEED, WARM, IDLE, SERVE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win;
  logic [W-1:0]   seed_sel;
  logic           lockup;
  logic [PW:0]    pick;

  // Handshake: a requester raises req and holds it until it sees its one-cycle gnt
  // pulse (rnd_valid/rnd_data qualify that same cycle); dropping req earlier withdraws it.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= N) j = j - N;
      if (r[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    pick = rr_pick(req, ptr);
  end

  assign busy = (state != IDLE);

`ifdef LFSR_LOCKUP_DET_EN
  logic [7:0] lockup_r;
  assign lockup     = (lfsr_q == '0);
  assign lockup_cnt = lockup_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lockup_r <= 8'h00;
    end else if (lockup && (state == IDLE || state == WARM) && lockup_r != 8'hFF) begin
      lockup_r <= lockup_r + 8'h01;
    end
  end
`else
  assign lockup     = 1'b0;
  assign lockup_cnt = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEED;
      seed_sel  <= SEED_DEFAULT;
      cnt       <= '0;
      ptr       <= '0;
      win       <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      lfsr_load <= 1'b0;
      lfsr_din  <= '0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      lfsr_load <= 1'b0;
      case (state)
        SEED: begin
          lfsr_load <= 1'b1;
          lfsr_din  <= seed_sel;
          cnt       <= CW'(GAP - 1);
          state     <= WARM;
        end
        WARM: begin
          if (lockup) begin
            seed_sel <= SEED_DEFAULT;
            state    <= SEED;
          end else if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          if (lockup) begin
            seed_sel <= SEED_DEFAULT;
            state    <= SEED;
          end else if (seed_req) begin
            // A zero seed would park the LFSR in its lockup state.
            seed_sel <= (seed_data == '0) ? SEED_DEFAULT : seed_data;
            state    <= SEED;
          end else if (pick[PW]) begin
            gnt       <= N'(1) << pick[PW-1:0];
            rnd_valid <= 1'b1;
            rnd_data  <= lfsr_q;
            win       <= pick[PW-1:0];
            state     <= SERVE;
          end
        end
        SERVE: begin
          ptr   <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
          cnt   <= CW'(GAP - 1);
          state <= WARM;
        end
        default: state <= SEED;
      endcase
    end
  end

endmodule
